alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//  Registered execute stage of the in-order pipeline. Selects operand B from
//  ReadData2, the sign-extended D-format address offset, or the sign-extended
//  12-bit immediate. Computes the ALU result and an architectural NZVC flag
//  register, with a valid/ready handshake on both sides. Adds an iterative
//  multi-cycle multiply that stalls the upstream stage while it runs.
// PARAMETERS
//  WIDTH    64  datapath width (A, B, result); must be >= IMM_W
//  DADDR_W  9   width of the D-format address offset, sign-extended to WIDTH
//  IMM_W    12  width of the I-format immediate, sign-extended to WIDTH
//  MUL_EN   1   1: op 3'b111 is MUL; 0: op 3'b111 behaves as pass-B
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-low reset
//  in_valid    in   1        upstream presents an operation
//  in_ready    out  1        stage accepts the operation this cycle
//  alu_src     in   1        0: B=read_data2; 1: B=extended constant
//  d_or_imm    in   1        constant select; 0: d_addr; 1: imm
//  d_addr      in   DADDR_W  D-format offset
//  imm         in   IMM_W    I-format immediate
//  alu_op      in   3        000 passB, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 mul
//  set_flags   in   1        commit NZVC of this op to the flag register
//  a           in   WIDTH    operand A
//  read_data2  in   WIDTH    register operand B
//  out_valid   out  1        result valid
//  out_ready   in   1        downstream accepts the result
//  result      out  WIDTH    registered result
//  flags       out  4        {N,Z,V,C} architectural flag register
//  busy        out  1        multiply in progress
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE; out_valid=0, result=0, flags=0,
//    busy=0, and any multiply in flight is discarded. in_ready=1 after release.
//  - Accept when in_valid&&in_ready. in_ready = (state!=MUL) && (!out_valid || out_ready).
//  - Unused ops 001 behave as pass-B; inputs are don't-care when not accepted.
//  - Single-cycle ops: result/out_valid registered on the accept edge (latency 1).
//    Back-to-back ops at one per cycle when out_ready=1.
//  - add/sub: C = carry out of bit WIDTH-1 (sub: A+~B+1, C=1 means no borrow).
//    V = signed overflow. N = result[WIDTH-1]. Z = (result==0).
//    Logic/pass: V=C=0.
//  - MUL (MUL_EN=1): FSM IDLE->MUL on accept. Shift-add, one multiplier bit per
//    cycle, WIDTH cycles. busy=1 throughout. Then the stage registers the low WIDTH
//    bits of A*B, asserts out_valid, and returns to IDLE (latency WIDTH+1).
//    N,Z from the product; V=C=0.
//  - Operands are captured at accept; input changes during MUL are ignored.
//  - flags updates in the same cycle out_valid rises, and only if set_flags was
//    captured with the op. Otherwise flags holds.
//  - out_valid && !out_ready: result and flags hold stable; no new op is accepted.
//  - Output accept and new input accept in the same cycle: the old result is
//    consumed and the new one replaces it without a gap.
// TESTING
//  1 add, A=64'h7FFF_FFFF_FFFF_FFFF, B=1, set_flags -> result=64'h8000_0000_0000_0000,
//    flags=4'b1010, out_valid 1 cycle after accept
//  2 sub, A=5, alu_src=1, d_or_imm=0, d_addr=9'h1FF (-1) -> B=-1, result=6,
//    C=0; flags unchanged when set_flags=0
//  3 mul, A=12345, B=678 -> busy high 64 cycles, in_ready=0 throughout,
//    result=8369910 at cycle 65
//  4 out_ready=0 for 3 cycles after and, A=F0, B=3C -> result=30 held, in_ready=0,
//    next op is accepted only on the release cycle
//  5 reset asserted at mul cycle 20 -> out_valid=0, busy=0, flags=0 immediately;
//    a subsequent add 2+3 -> 5
//  6 stream of 8 adds with out_ready=1 -> 8 results on 8 consecutive cycles, in order

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute stage with operand-B select, NZVC flag register,
// valid/ready handshake on both sides and an iterative shift-add multiplier.
module alu_exec_stage #(
    parameter int WIDTH   = 64,
    parameter int DADDR_W = 9,
    parameter int IMM_W   = 12,
    parameter bit MUL_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               alu_src,
    input  logic               d_or_imm,
    input  logic [DADDR_W-1:0] d_addr,
    input  logic [IMM_W-1:0]   imm,
    input  logic [2:0]         alu_op,
    input  logic               set_flags,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   read_data2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             sf_q, sf_d;

    logic [WIDTH-1:0] b, res, acc_next;
    logic [WIDTH:0]   sum;
    logic             accept, is_sub, is_arith, is_mul, v;

    assign in_ready  = (state_q != S_MUL) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign busy      = (state_q == S_MUL);

    always_comb begin
        b = !alu_src ? read_data2
          : d_or_imm ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm}
          : {{(WIDTH-DADDR_W){d_addr[DADDR_W-1]}}, d_addr};
        is_sub   = (alu_op == 3'b011);
        is_arith = (alu_op == 3'b010) || is_sub;
        is_mul   = MUL_EN && (alu_op == 3'b111);
        // Subtraction is A + ~B + 1 so the carry out means "no borrow".
        sum = is_sub ? {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1) : {1'b0, a} + {1'b0, b};
        v   = (is_sub ? (a[WIDTH-1] != b[WIDTH-1]) : (a[WIDTH-1] == b[WIDTH-1]))
              && (sum[WIDTH-1] != a[WIDTH-1]);
        res = is_arith             ? sum[WIDTH-1:0]
            : alu_op == 3'b100     ? a & b
            : alu_op == 3'b101     ? a | b
            : alu_op == 3'b110     ? a ^ b
            : b;
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q && !out_ready;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sf_d        = sf_q;
        if (state_q == S_MUL) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                state_d     = S_IDLE;
                result_d    = acc_next;
                out_valid_d = 1'b1;
                if (sf_q) flags_d = {acc_next[WIDTH-1], acc_next == '0, 2'b00};
            end
        end else if (accept) begin
            if (is_mul) begin
                state_d  = S_MUL;
                mcand_d  = a;
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
                sf_d     = set_flags;
            end else begin
                result_d    = res;
                out_valid_d = 1'b1;
                if (set_flags) flags_d = {res[WIDTH-1], res == '0, is_arith && v, is_arith && sum[WIDTH]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sf_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sf_q        <= sf_d;
        end
    end
endmodule
